// File: rtl/uart_prog_loader.sv
// uart_prog_loader
// ----------------
// Receives a program image over an 8N1 UART line (idle high, LSB first) and
// writes it word by word into an instruction memory through a req/gnt port.
// Four bytes form one word, MSB first. The word END_WORD is never written.
// It ends the load, and all input after it is ignored until reset.
//
// Optional feature macro: UART_LOADER_CHECKSUM_EN
//   defined   -> checksum_o is the running modulo-2^32 sum of granted words
//   undefined -> checksum_o is tied to 0 and no adder exists
//
// Handshake (mem_req_o / mem_gnt_i): a write is offered by raising mem_req_o
// with mem_addr_o/mem_wdata_o. All three hold steady until a rising clk_i
// edge samples mem_gnt_i high with mem_req_o high. That edge completes the
// transfer, drops mem_req_o and bumps word_count_o. mem_gnt_i is ignored while
// mem_req_o is low.
//
// Ports
//   clk_i         the only clock
//   rst_i         synchronous active-high reset
//   uart_rx_i     serial program stream (asynchronous to clk_i)
//   ready_o       high while waiting for / receiving program words
//   mem_req_o     write request
//   mem_gnt_i     write grant
//   mem_addr_o    word address of the pending write
//   mem_wdata_o   data of the pending write
//   done_o        terminator received and all writes finished
//   word_count_o  number of words committed to memory
//   frame_err_o   sticky: a byte had a low stop bit
//   overrun_o     sticky: a word arrived while a write was pending
//   overflow_o    sticky: a word arrived after memory was full
//   checksum_o    running sum of committed words (see macro above)
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rx_i,
    output logic              ready_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              overflow_o,
    output logic [31:0]       checksum_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [1:0] rx_sync;
    logic       rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) rx_sync <= 2'b11;
        else       rx_sync <= {rx_sync[0], uart_rx_i};
    end

    assign rx_s = rx_sync[1];

    // ------------------------------------------------------------------
    // Byte receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             cnt_clr, shift_en, byte_ok, byte_bad;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            clk_cnt  <= cnt_clr ? '0 : clk_cnt + 1'b1;
            if (rx_state == RX_IDLE) bit_idx <= '0;
            if (shift_en) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                bit_idx  <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        rx_next  = rx_state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) rx_next = RX_START;
            end
            RX_START: begin
                // Mid start bit: a high line here was only a glitch.
                if (clk_cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    rx_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    byte_ok  = rx_s;
                    byte_bad = !rx_s;
                    rx_next  = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Word assembly and memory write port
    // ------------------------------------------------------------------
    logic [1:0]  byte_idx;
    logic [23:0] word_hi;
    logic        term_pend;   // terminator seen, waiting for last grant
    logic        accept;
    logic        word_done;
    logic [31:0] word_full;
    logic        mem_full;
    logic        gnt_hit;

    assign accept    = !done_o && !term_pend;
    assign word_full = {word_hi, rx_shift};
    assign word_done = accept && byte_ok && (byte_idx == 2'd3);
    assign mem_full  = word_count_o[ADDR_W];
    assign gnt_hit   = mem_req_o && mem_gnt_i;
    assign ready_o   = !done_o && !term_pend;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_idx     <= '0;
            word_hi      <= '0;
            term_pend    <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            word_count_o <= '0;
            done_o       <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            if (accept) begin
                if (byte_bad) begin
                    // Drop the byte and realign to a word boundary.
                    frame_err_o <= 1'b1;
                    byte_idx    <= '0;
                end else if (byte_ok) begin
                    word_hi  <= {word_hi[15:0], rx_shift};
                    byte_idx <= byte_idx + 2'd1;
                end
            end

            if (word_done) begin
                if (word_full == END_WORD) begin
                    // A write still outstanding after this edge defers done.
                    if (mem_req_o && !mem_gnt_i) term_pend <= 1'b1;
                    else                         done_o    <= 1'b1;
                end else if (mem_req_o) begin
                    overrun_o <= 1'b1;
                end else if (mem_full) begin
                    overflow_o <= 1'b1;
                end else begin
                    mem_req_o   <= 1'b1;
                    mem_addr_o  <= word_count_o[ADDR_W-1:0];
                    mem_wdata_o <= word_full;
                end
            end

            if (gnt_hit) begin
                mem_req_o    <= 1'b0;
                word_count_o <= word_count_o + 1'b1;
                if (term_pend) begin
                    term_pend <= 1'b0;
                    done_o    <= 1'b1;
                end
            end
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)        checksum_q <= '0;
        else if (gnt_hit) checksum_q <= checksum_q + mem_wdata_o;
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'd0;
`endif

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87; clk_i cycles per UART bit (115200 baud at 10 MHz).
REQ-002 SHALL have parameter ADDR_W, default 14; word-address width of the instruction memory (16384 words).
REQ-003 SHALL have parameter END_WORD, default 32'h00000FFF; terminator word that ends a load.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i in 1, the only clock; rst_i in 1, synchronous active-high reset.
REQ-005 SHALL have uart_rx_i in 1: serial program stream, idle high, 8N1, LSB first.
REQ-006 SHALL have ready_o out 1: high while the loader waits for or receives program words.
REQ-007 SHALL have mem_req_o out 1 and mem_gnt_i in 1: write request and its grant.
REQ-008 SHALL have mem_addr_o out ADDR_W and mem_wdata_o out 32: word address and data.
REQ-009 SHALL have done_o out 1: terminator received, load complete.
REQ-010 SHALL have word_count_o out ADDR_W+1: words committed to memory.
REQ-011 SHALL have frame_err_o, overrun_o and overflow_o out 1 each: sticky error flags.
REQ-012 SHALL have checksum_o out 32: running sum of committed words.

Function
REQ-013 SHALL pass uart_rx_i through a 2-flop synchronizer (reset value 1) before any use.
REQ-014 RX FSM SHALL have states IDLE, START, DATA, STOP: IDLE->START on a sampled low; START checks the line at CLKS_PER_BIT/2 and returns to IDLE if it is high (glitch); DATA samples 8 bits every CLKS_PER_BIT cycles; STOP samples one bit, then IDLE.
REQ-015 SHALL tolerate a start bit stretched by up to 0.15 bit period (the TB adds 1000 ns) without bit errors.
REQ-016 If the stop bit is 0, SHALL discard the byte, set frame_err_o, and reset the byte index to 0 (resync to a word boundary).
REQ-017 SHALL assemble 4 valid bytes MSB first (byte 0 -> [31:24] ... byte 3 -> [7:0]) into one word.
REQ-018 When a word equals END_WORD, SHALL not write it, SHALL assert done_o and deassert ready_o on the next cycle, and SHALL ignore all further input until reset.
REQ-019 For any other word, SHALL raise mem_req_o the cycle after the 4th byte's stop bit, with mem_addr_o = word_count_o[ADDR_W-1:0].
REQ-020 SHALL hold mem_req_o, mem_addr_o and mem_wdata_o stable until the cycle in which mem_gnt_i is sampled high; SHALL then drop mem_req_o the next cycle and increment word_count_o.
REQ-021 If a word completes while a write is still pending, SHALL drop the new word and set overrun_o; the pending write is unaffected.
REQ-022 Once word_count_o reaches 2^ADDR_W, SHALL discard further non-terminator words and set overflow_o; the address SHALL never wrap.
REQ-023 A terminator that arrives while a write is pending SHALL assert done_o only after that write is granted.
REQ-024 mem_gnt_i asserted while mem_req_o is low SHALL be ignored.

Reset
REQ-025 On rst_i sampled high, SHALL set: RX FSM IDLE; byte index 0; mem_req_o 0; mem_addr_o 0; mem_wdata_o 0; word_count_o 0; done_o 0; all error flags 0; checksum_o 0; synchronizer 1. ready_o SHALL be 1 from the first cycle after reset.
REQ-026 Reset asserted mid-byte or mid-write SHALL abort the operation immediately, issue no further request, and keep the partial byte or word out of memory.

Configuration
REQ-027 With UART_LOADER_CHECKSUM_EN defined, checksum_o SHALL add each granted word modulo 2^32 in its grant cycle; without the macro, checksum_o SHALL be constant 0 and no adder SHALL be synthesized.

Verification
REQ-028 Send bytes 00 00 00 13, 00 00 0F FF, with mem_gnt_i 1 cycle after req -> one write, addr 0, data 32'h00000013; then done_o=1, ready_o=0, word_count_o=1.
REQ-029 Send 3 words with the start bit stretched 1000 ns and gnt delayed 50 cycles -> addrs 0,1,2 in order, data exact, req held stable all 50 cycles, no error flags.
REQ-030 Send byte 8'hAB with stop bit 0, then a full word 32'hDEADBEEF -> frame_err_o=1, one write of 32'hDEADBEEF at addr 0.
REQ-031 Hold mem_gnt_i low for 2 word times -> overrun_o=1, only the first word is written after the grant, word_count_o=1.
REQ-032 Assert rst_i during bit 4 of the second byte -> no request; after reset a clean word is written to addr 0.
REQ-033 With UART_LOADER_CHECKSUM_EN, send words 32'hFFFFFFFF and 32'h00000002 -> checksum_o=32'h00000001; without the macro, checksum_o=0.
